// File: rtl/fb_readback.sv
// Frame-buffer readback: fetches BURST-word SDRAM reads into a word FIFO
// and serialises each word to the transmit path as two bytes, low byte first.
module fb_readback #(
  parameter int unsigned FIFO_AW = 5,
  parameter int unsigned BURST   = 8
) (
  input  logic        mem_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [24:0] cmd_addr,
  input  logic [15:0] cmd_len,
  output logic        cmd_ready,
  input  logic        mem_idle,
  output logic        mem_rd_req,
  output logic [24:0] mem_rd_addr,
  input  logic        mem_ack,
  input  logic        mem_rd_valid,
  input  logic [15:0] mem_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);
  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CNT_W  = FIFO_AW + 1;
  localparam int unsigned BEAT_W = $clog2(BURST + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DRAIN} state_t;
  state_t state, state_nxt;

  logic [15:0]        fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [15:0]        rd_word;
  logic [15:0]        bursts_left, bursts_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
  logic [24:0]        addr_nxt;
  logic [7:0]         hi_byte;
  logic               req_nxt, done_nxt, fifo_wr, fifo_rd;
  logic               tx_take, tx_hi, space_ok, fifo_empty;

  assign rd_word    = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_cnt == '0);
  // A burst is only requested when the whole burst is guaranteed to fit.
  assign space_ok   = (CNT_W'(DEPTH) - fifo_cnt) >= CNT_W'(BURST);
  assign tx_take    = tx_valid & tx_ready;
  assign fifo_rd    = !fifo_empty && (!tx_valid || (tx_take && tx_hi));

  always_ff @(posedge mem_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_nxt    = mem_rd_req;
    addr_nxt   = mem_rd_addr;
    bursts_nxt = bursts_left;
    beat_nxt   = beat_cnt;
    done_nxt   = 1'b0;
    fifo_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            addr_nxt   = cmd_addr & ~25'h7;
            bursts_nxt = cmd_len;
            state_nxt  = REQ;
          end
        end
      end
      REQ: begin
        if (mem_rd_req) begin
          if (mem_ack) begin
            req_nxt    = 1'b0;
            addr_nxt   = mem_rd_addr + 25'(BURST);
            bursts_nxt = bursts_left - 16'd1;
            beat_nxt   = '0;
            state_nxt  = WAIT_DATA;
          end
        end else if (mem_idle && space_ok) begin
          req_nxt = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (mem_rd_valid) begin
          fifo_wr  = 1'b1;
          beat_nxt = beat_cnt + BEAT_W'(1);
          if (beat_cnt == BEAT_W'(BURST - 1))
            state_nxt = (bursts_left != '0) ? REQ : DRAIN;
        end
      end
      DRAIN: begin
        // Finished once the high byte of the final word is accepted.
        if (fifo_empty && (!tx_valid || (tx_take && tx_hi))) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= mem_rd_data;
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
      bursts_left <= '0;
      beat_cnt    <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      tx_hi       <= 1'b0;
      hi_byte     <= '0;
    end else begin
      mem_rd_req  <= req_nxt;
      mem_rd_addr <= addr_nxt;
      bursts_left <= bursts_nxt;
      beat_cnt    <= beat_nxt;
      done        <= done_nxt;
      busy        <= (state_nxt != IDLE);
      cmd_ready   <= (state_nxt == IDLE);
      if (fifo_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
      // Byte serialiser: load a word, send low byte, then high byte.
      if (fifo_rd) begin
        tx_data  <= rd_word[7:0];
        hi_byte  <= rd_word[15:8];
        tx_valid <= 1'b1;
        tx_hi    <= 1'b0;
        rd_ptr   <= rd_ptr + FIFO_AW'(1);
      end else if (tx_take) begin
        if (!tx_hi) begin
          tx_data <= hi_byte;
          tx_hi   <= 1'b1;
        end else begin
          tx_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fb_readback.sv
// Directed bench for fb_readback: byte scoreboard fed from driven beats,
// checked as bytes are accepted on the transmit side.
module tb_fb_readback;
  logic        mem_clk;
  logic        rst;
  logic        cmd_valid;
  logic [24:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_ready;
  logic        mem_idle;
  logic        mem_rd_req;
  logic [24:0] mem_rd_addr;
  logic        mem_ack;
  logic        mem_rd_valid;
  logic [15:0] mem_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int req_cnt  = 0;
  int byte_cnt = 0;
  logic req_prev = 1'b0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  fb_readback #(.FIFO_AW(3), .BURST(8)) dut (
    .mem_clk(mem_clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .mem_idle(mem_idle), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_ack(mem_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bytes accepted at the next rising edge are sampled mid-cycle.
  always @(negedge mem_clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_rd_req === 1'b1 && req_prev !== 1'b1) req_cnt++;
    req_prev = mem_rd_req;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      byte_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL tx_unexpected: observed %h expected no byte", tx_data);
      end else begin
        exp_b = sb.pop_front();
        check("tx_byte", 32'(tx_data), 32'(exp_b));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic issue(input logic [24:0] a, input logic [15:0] l);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input logic [24:0] exp_addr, input int max_cyc);
    int i = 0;
    while (mem_rd_req !== 1'b1 && i < max_cyc) begin
      step();
      i++;
    end
    check("req_seen", 32'(mem_rd_req), 32'd1);
    check("req_addr", 32'(mem_rd_addr), 32'(exp_addr));
  endtask

  task automatic do_ack();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("req_drop_after_ack", 32'(mem_rd_req), 32'd0);
  endtask

  task automatic send_beats(input logic [15:0] base, input int n, input bit push, input bit lat);
    for (int k = 0; k < n; k++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = base + 16'(k);
      if (push) begin
        sb.push_back(mem_rd_data[7:0]);
        sb.push_back(mem_rd_data[15:8]);
      end
      step();
      if (lat && k == 1) check("first_byte_latency", 32'(tx_valid), 32'd1);
    end
    mem_rd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int i = 0;
    while (done !== 1'b1 && i < max_cyc) begin
      step();
      i++;
    end
    check("done_pulse", 32'(done), 32'd1);
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int d0, r0, b0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    mem_idle = 1'b1; mem_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    tx_ready = 1'b1;
    step(); step();
    check("rst_req", 32'(mem_rd_req), 32'd0);
    check("rst_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    step();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic command: unaligned address, ack held off three cycles
    d0 = done_cnt; b0 = byte_cnt;
    issue(25'h0000013, 16'd1);
    check("busy_after_cmd", 32'(busy), 32'd1);
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    wait_req(25'h0000010, 20);
    for (int i = 0; i < 3; i++) begin
      step();
      check("req_hold", 32'({mem_rd_req, mem_rd_addr}), 32'({1'b1, 25'h0000010}));
    end
    do_ack();
    send_beats(16'h1100, 8, 1'b1, 1'b1);
    wait_done(200);
    check("basic_bytes", 32'(byte_cnt - b0), 32'd16);
    check("basic_done_count", 32'(done_cnt - d0), 32'd1);

    // Arbitration: request withheld while the port is busy, then held once raised
    mem_idle = 1'b0;
    r0 = req_cnt;
    issue(25'h0000100, 16'd1);
    for (int i = 0; i < 20; i++) step();
    check("arb_no_req_while_busy", 32'(req_cnt - r0), 32'd0);
    mem_idle = 1'b1;
    step();
    check("arb_req_after_idle", 32'(mem_rd_req), 32'd1);
    mem_idle = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("arb_req_held", 32'({mem_rd_req, mem_rd_addr}), 32'({1'b1, 25'h0000100}));
    do_ack();
    mem_idle = 1'b1;
    send_beats(16'h2200, 8, 1'b1, 1'b0);
    wait_done(200);

    // Back-pressure: with 8-word FIFO only one burst fits until the output drains
    tx_ready = 1'b0;
    r0 = req_cnt; b0 = byte_cnt;
    issue(25'h0000400, 16'd4);
    wait_req(25'h0000400, 20);
    do_ack();
    send_beats(16'h3000, 8, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) step();
    check("bp_single_request", 32'(req_cnt - r0), 32'd1);
    check("bp_req_withheld", 32'(mem_rd_req), 32'd0);
    check("bp_head_byte", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h00}));
    tx_ready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      wait_req(25'h0000400 + 25'(8 * b), 200);
      do_ack();
      send_beats(16'h3000 + 16'(16 * b), 8, 1'b1, 1'b0);
    end
    wait_done(400);
    check("bp_total_bytes", 32'(byte_cnt - b0), 32'd64);

    // Address wrap and foreign beats outside WAIT_DATA
    b0 = byte_cnt;
    send_beats(16'hDEAD, 2, 1'b0, 1'b0);
    issue(25'h1FFFFF8, 16'd2);
    send_beats(16'hBEEF, 2, 1'b0, 1'b0);
    wait_req(25'h1FFFFF8, 20);
    do_ack();
    send_beats(16'h4400, 8, 1'b1, 1'b0);
    send_beats(16'hCAFE, 2, 1'b0, 1'b0);
    wait_req(25'h0000000, 200);
    do_ack();
    send_beats(16'h4500, 8, 1'b1, 1'b0);
    wait_done(200);
    check("wrap_total_bytes", 32'(byte_cnt - b0), 32'd32);

    // Zero-length command
    d0 = done_cnt; r0 = req_cnt;
    issue(25'h0000200, 16'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    step();
    check("len0_done_clear", 32'(done), 32'd0);
    check("len0_no_req", 32'(req_cnt - r0), 32'd0);
    check("len0_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset in WAIT_DATA after three beats
    tx_ready = 1'b0;
    b0 = byte_cnt;
    issue(25'h0000800, 16'd1);
    wait_req(25'h0000800, 20);
    do_ack();
    send_beats(16'h5500, 3, 1'b0, 1'b0);
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_outputs", 32'({mem_rd_req, mem_rd_addr, tx_valid, tx_data, busy, done}), 32'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    send_beats(16'h5503, 5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("post_rst_tx_idle", 32'(tx_valid), 32'd0);
    check("post_rst_cmd_ready", 32'({cmd_ready, busy}), 32'b10);
    check("post_rst_no_bytes", 32'(byte_cnt - b0), 32'd0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_readback.md
FB_READBACK -- requirements
Module: fb_readback

Interface
REQ-001 Parameter FIFO_AW, default 5, sets the word-FIFO depth to 2^FIFO_AW 16-bit words (minimum 4).
REQ-002 Parameter BURST, default 8, sets the words per SDRAM read request; it SHALL match the controller's read burst mode.
REQ-003 Port mem_clk, input, 1: the only clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port cmd_valid, input, 1: start readback; sampled only when cmd_ready=1.
REQ-006 Port cmd_addr, input, 25: start word address; bits [2:0] SHALL be ignored and treated as 0.
REQ-007 Port cmd_len, input, 16: number of BURST-word bursts to read.
REQ-008 Port cmd_ready, output, 1: high only in IDLE.
REQ-009 Port mem_idle, input, 1: high when the shared controller port is free of video read requests.
REQ-010 Port mem_rd_req, output, 1: read request to the SDRAM controller.
REQ-011 Port mem_rd_addr, output, 25: request word address.
REQ-012 Port mem_ack, input, 1: controller accepted the request.
REQ-013 Port mem_rd_valid, input, 1: read data beat valid.
REQ-014 Port mem_rd_data, input, 16: read data beat.
REQ-015 Port tx_data, output, 8: byte toward the FTDI transmit path.
REQ-016 Port tx_valid, output, 1: tx_data is valid.
REQ-017 Port tx_ready, input, 1: the byte is consumed when tx_valid and tx_ready are both high.
REQ-018 Port busy, output, 1: high whenever the state is not IDLE.
REQ-019 Port done, output, 1: one-cycle pulse when the command completes.

Function
REQ-020 The block SHALL implement four states: IDLE, REQ, WAIT_DATA and DRAIN.
REQ-021 In IDLE, cmd_valid=1 with cmd_len=0 SHALL pulse done on the next cycle, issue no request, and stay in IDLE.
REQ-022 In IDLE, cmd_valid=1 with cmd_len>0 SHALL latch {cmd_addr[24:3],3'b000} and cmd_len, then go to REQ.
REQ-023 In REQ, mem_rd_req SHALL rise only when mem_idle=1 and FIFO free space >= BURST.
- Once raised, mem_rd_req and mem_rd_addr SHALL hold stable until mem_ack, regardless of mem_idle.
REQ-024 On mem_ack while mem_rd_req=1:
- mem_rd_req SHALL drop on the next cycle.
- The address SHALL advance by BURST, modulo 2^25 (0x1FFFFF8 wraps to 0x0000000).
- The remaining-burst count SHALL decrement.
- The state SHALL go to WAIT_DATA.
REQ-025 In WAIT_DATA, each mem_rd_valid beat SHALL be written to the FIFO.
- After BURST beats: go to REQ if bursts remain, else DRAIN.
- mem_rd_valid outside WAIT_DATA SHALL be ignored, since those beats belong to the video reader.
REQ-026 At most one request SHALL be outstanding at any time.
REQ-027 FIFO overflow SHALL be impossible by construction, via the REQ-023 space check.
REQ-028 Output serialisation: each FIFO word SHALL be sent as two bytes, low byte [7:0] first, then high byte [15:8].
- tx_valid SHALL be high whenever a byte is available.
- tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-029 FIFO write and read in the same cycle SHALL both take effect; the level SHALL stay unchanged.
REQ-030 Output SHALL run concurrently with REQ and WAIT_DATA; the first byte SHALL reach tx_valid no later than 2 cycles after the first beat is written.
REQ-031 In DRAIN, the block SHALL wait until the FIFO is empty and the high-byte phase is complete.
- Completion SHALL be the cycle the last byte is accepted.
- done SHALL pulse on the next cycle and the state SHALL return to IDLE.
REQ-032 Total bytes per command SHALL be exactly 2*BURST*cmd_len.

Reset
REQ-033 rst=1 SHALL take effect on the next rising edge, including mid-operation:
- State goes to IDLE, FIFO and byte phase are flushed, counters clear.
- Outputs: mem_rd_req=0, mem_rd_addr=0, tx_valid=0, tx_data=0, busy=0, done=0, cmd_ready=1 once rst deasserts.
REQ-034 Beats arriving after a mid-operation reset SHALL be discarded, because IDLE ignores mem_rd_valid.

Verification
REQ-035 Basic command: cmd_addr=0x0000013, cmd_len=1, mem_idle=1, ack after 3 cycles, beats 0x1100..0x1107 -> request addr 0x0000010; 16 bytes 00,11,01,11,...,07,11; one done pulse.
REQ-036 Arbitration: mem_idle=0 for 20 cycles after cmd -> mem_rd_req stays 0 throughout; it rises the cycle after mem_idle=1.
- mem_idle dropping after mem_rd_req is raised -> request held until ack.
REQ-037 Back-pressure: FIFO_AW=3, cmd_len=4, tx_ready=0 -> exactly one request acked and 8 words buffered.
- The second request is withheld until >=8 words of space exist.
- Releasing tx_ready yields all 64 bytes in order with no loss or duplication.
REQ-038 Wrap and foreign beats: cmd_addr=0x1FFFFF8, cmd_len=2 -> request addresses 0x1FFFFF8 then 0x0000000.
- Beats injected in REQ state are not emitted.
REQ-039 Edge commands: cmd_len=0 -> done one cycle later, no mem_rd_req.
- rst pulsed in WAIT_DATA after 3 beats -> all outputs at reset values next cycle; the remaining 5 beats are ignored; cmd_ready=1.
